// File: rtl/pe_layer_sequencer.sv
// Tile sequencer for a PE array: clear, weight load, input load, drain, output write.
// Optional macro SEQ_PERF_CNT_EN adds a saturating busy-cycle counter on perf_cycles.
module pe_layer_sequencer #(
  parameter int COMPUTE_WAIT = 4,
  parameter int OUT_BEATS    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  cfg_conv_num,
  input  logic        cfg_relu,
  input  logic        cfg_pool,
  input  logic        cfg_partial,
  input  logic [16:0] cfg_w_base,
  input  logic [16:0] cfg_w_len,
  input  logic [10:0] cfg_i_base,
  input  logic [10:0] cfg_i_len,
  input  logic [14:0] cfg_o_base,
  input  logic        readdatavalid_out_weight,
  input  logic        readdatavalid_out_input,
  input  logic        write_output,
  input  logic        waitrequest_output,
  output logic        rst_n_pe,
  output logic        en_readw_control,
  output logic        en_readi_control,
  output logic        en_write_control,
  output logic [16:0] addr_readw_control,
  output logic [10:0] addr_readi_control,
  output logic [14:0] addr_write_control,
  output logic [3:0]  conv_num,
  output logic        relu_en_control,
  output logic        pool_en_control,
  output logic        partial_en_control,
  output logic        output_en_control,
  output logic        busy,
  output logic        done,
  output logic [31:0] perf_cycles
);

  typedef enum logic [2:0] {IDLE, CLR, LOAD_W, LOAD_I, DRAIN, WRITE, DONE} state_t;

  localparam int OCNT_W = $clog2(OUT_BEATS + 1);
  localparam int DCNT_W = $clog2(COMPUTE_WAIT + 2);
  localparam logic [OCNT_W-1:0] BEATS_FULL = OCNT_W'(OUT_BEATS);
  localparam logic [OCNT_W-1:0] BEATS_POOL = OCNT_W'(OUT_BEATS / 2);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = (COMPUTE_WAIT > 0) ? DCNT_W'(COMPUTE_WAIT - 1) : '0;

  state_t state, next_state;

  logic [16:0]       w_base_q, w_len_q, wcnt;
  logic [10:0]       i_base_q, i_len_q, icnt;
  logic [14:0]       o_base_q;
  logic [DCNT_W-1:0] dcnt;
  logic [OCNT_W-1:0] ocnt, beat_target;
  logic              rd_pending;
  logic              w_beat, i_beat, wr_beat;

  assign beat_target = pool_en_control ? BEATS_POOL : BEATS_FULL;

  // NOTE: synchronous reset; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state        = state;
    busy              = 1'b0;
    done              = 1'b0;
    en_readw_control  = 1'b0;
    en_readi_control  = 1'b0;
    output_en_control = 1'b0;
    w_beat            = 1'b0;
    i_beat            = 1'b0;
    wr_beat           = 1'b0;
    unique case (state)
      IDLE: if (start) next_state = CLR;
      CLR: begin
        busy = 1'b1;
        if (w_len_q != '0)      next_state = LOAD_W;
        else if (i_len_q != '0) next_state = LOAD_I;
        else                    next_state = DRAIN;
      end
      LOAD_W: begin
        busy             = 1'b1;
        en_readw_control = !rd_pending;
        // A valid beat only counts while our single read is in flight.
        w_beat           = rd_pending && readdatavalid_out_weight;
        if (w_beat && (wcnt + 17'd1 == w_len_q))
          next_state = (i_len_q != '0) ? LOAD_I : DRAIN;
      end
      LOAD_I: begin
        busy             = 1'b1;
        en_readi_control = !rd_pending;
        i_beat           = rd_pending && readdatavalid_out_input;
        if (i_beat && (icnt + 11'd1 == i_len_q)) next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (dcnt == DRAIN_LAST) next_state = WRITE;
      end
      WRITE: begin
        busy              = 1'b1;
        output_en_control = 1'b1;
        wr_beat           = write_output && !waitrequest_output;
        if (wr_beat && (ocnt + OCNT_W'(1) == beat_target)) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_pe           <= 1'b0;
      en_write_control   <= 1'b0;
      addr_readw_control <= '0;
      addr_readi_control <= '0;
      addr_write_control <= '0;
      conv_num           <= '0;
      relu_en_control    <= 1'b0;
      pool_en_control    <= 1'b0;
      partial_en_control <= 1'b0;
      w_base_q           <= '0;
      w_len_q            <= '0;
      i_base_q           <= '0;
      i_len_q            <= '0;
      o_base_q           <= '0;
      wcnt               <= '0;
      icnt               <= '0;
      dcnt               <= '0;
      ocnt               <= '0;
      rd_pending         <= 1'b0;
    end else begin
      rst_n_pe         <= (next_state != CLR);
      en_write_control <= (next_state == WRITE) && (state != WRITE);

      if (state == IDLE && start) begin
        conv_num           <= cfg_conv_num;
        relu_en_control    <= cfg_relu;
        pool_en_control    <= cfg_pool;
        partial_en_control <= cfg_partial;
        w_base_q           <= cfg_w_base;
        w_len_q            <= cfg_w_len;
        i_base_q           <= cfg_i_base;
        i_len_q            <= cfg_i_len;
        o_base_q           <= cfg_o_base;
      end

      if (state == CLR) begin
        wcnt <= '0;
        icnt <= '0;
      end

      if (next_state == LOAD_W && state != LOAD_W) addr_readw_control <= w_base_q;
      if (next_state == LOAD_I && state != LOAD_I) addr_readi_control <= i_base_q;
      if (next_state == WRITE && state != WRITE)   addr_write_control <= o_base_q;

      if (en_readw_control || en_readi_control) rd_pending <= 1'b1;

      // Address only advances when another read will follow, so it holds the last one issued.
      if (w_beat) begin
        rd_pending <= 1'b0;
        wcnt       <= wcnt + 17'd1;
        if (wcnt + 17'd1 != w_len_q) addr_readw_control <= addr_readw_control + 17'd1;
      end
      if (i_beat) begin
        rd_pending <= 1'b0;
        icnt       <= icnt + 11'd1;
        if (icnt + 11'd1 != i_len_q) addr_readi_control <= addr_readi_control + 11'd1;
      end

      dcnt <= (state == DRAIN) ? dcnt + DCNT_W'(1) : '0;

      if (state != WRITE) ocnt <= '0;
      else if (wr_beat)   ocnt <= ocnt + OCNT_W'(1);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                    perf_q <= '0;
    else if (state == IDLE && start) perf_q <= '0;
    else if (busy && perf_q != '1) perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: doc/pe_layer_sequencer.md
PE_LAYER_SEQUENCER -- requirements
Module: pe_layer_sequencer

Interface
REQ-001 SHALL have parameter COMPUTE_WAIT, default 4: drain cycles between last input beat and write phase.
REQ-002 SHALL have parameter OUT_BEATS, default 64: 16-bit output beats per tile without pooling. With pooling the count is OUT_BEATS/2.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; launches one tile; ignored unless IDLE.
REQ-006 cfg_conv_num  in  4  layer select; cfg_relu, cfg_pool, cfg_partial  in  1 each.
REQ-007 cfg_w_base  in  17, cfg_w_len  in  17: weight base and 1024-bit word count.
REQ-008 cfg_i_base  in  11, cfg_i_len  in  11: input base and 16-bit word count.
REQ-009 cfg_o_base  in  15: output base address.
REQ-010 readdatavalid_out_weight, readdatavalid_out_input  in  1: read-beat returns.
REQ-011 write_output, waitrequest_output  in  1: write-master status, used for beat counting.
REQ-012 rst_n_pe, en_readw_control, en_readi_control, en_write_control  out  1 each.
REQ-013 addr_readw_control  out  17, addr_readi_control  out  11, addr_write_control  out  15.
REQ-014 conv_num  out  4; relu_en_control, pool_en_control, partial_en_control, output_en_control  out  1 each.
REQ-015 busy  out  1; done  out  1 (one-cycle pulse); perf_cycles  out  32.

Function
REQ-016 States SHALL be IDLE, CLR, LOAD_W, LOAD_I, DRAIN, WRITE, DONE.
REQ-017 On start in IDLE, SHALL latch all cfg_* inputs, enter CLR, and raise busy the next cycle.
REQ-018 Latched conv_num, relu, pool and partial SHALL drive the outputs until the next start.
REQ-019 CLR SHALL hold rst_n_pe=0 for exactly 1 cycle, then go to LOAD_W.
REQ-020 LOAD_W SHALL keep one read outstanding at a time:
  - pulse en_readw_control for 1 cycle with addr_readw_control = w_base + k;
  - wait for readdatavalid_out_weight, then k++.
REQ-021 After cfg_w_len beats, or immediately if cfg_w_len=0, SHALL go to LOAD_I.
REQ-022 LOAD_I SHALL behave like LOAD_W, using the input ports, i_base and i_len.
REQ-023 After the last input beat SHALL go to DRAIN for COMPUTE_WAIT cycles, then WRITE.
REQ-024 On entry to WRITE SHALL pulse en_write_control for 1 cycle with addr_write_control = o_base.
REQ-025 output_en_control SHALL be 1 throughout WRITE.
REQ-026 WRITE SHALL count beats where write_output=1 and waitrequest_output=0; at OUT_BEATS (OUT_BEATS/2 if pool), go to DONE.
REQ-027 DONE SHALL pulse done for 1 cycle, drop busy, and return to IDLE.
REQ-028 A valid beat arriving in a cycle with no read outstanding SHALL be ignored.
REQ-029 start while busy SHALL be ignored, with no effect on the latched config.
REQ-030 Address adds SHALL wrap modulo port width, with no saturation.
REQ-031 Beat counters SHALL be 17 bits (weight) and 11 bits (input); a count equal to len ends the phase.
REQ-032 Outside their owning states, all en_* pulses and output_en_control SHALL be 0; addresses hold their last value.

Reset
REQ-033 When rst_n=0 at an edge, SHALL go to IDLE from any state, including mid-phase.
REQ-034 Reset values: busy=0, done=0, all en_*=0, output_en_control=0, rst_n_pe=0.
REQ-035 Reset values: addresses=0, conv_num=0, relu/pool/partial=0, counters=0, perf_cycles=0.
REQ-036 In IDLE after reset, rst_n_pe SHALL be 1.
REQ-037 Reset SHALL discard any outstanding read; its late valid beat is ignored per REQ-028.

Configuration
REQ-038 Macro SEQ_PERF_CNT_EN defined: perf_cycles SHALL count cycles with busy=1, cleared on each accepted start and saturating at 2^32-1.
REQ-039 Macro SEQ_PERF_CNT_EN undefined: perf_cycles SHALL be constant 0, with no counter logic.

Verification
REQ-040 w_len=2, i_len=3, valid 2 cycles after each en; pool=0, no waitrequest:
  - expected: 2 weight pulses at addr w_base and w_base+1, then 3 input pulses;
  - then DRAIN 4 cycles, 1 write pulse at o_base, then done after 64 write beats.
REQ-041 pool=1, waitrequest_output toggling every other cycle -> done after exactly 32 accepted beats.
REQ-042 w_len=0, i_len=1 -> LOAD_W skipped; the single input read is issued immediately after CLR.
REQ-043 i_base=0x7FF, i_len=2 -> addresses 0x7FF then 0x000.
REQ-044 rst_n=0 mid-LOAD_I -> IDLE next cycle, all outputs at reset values; a later stray valid beat causes no state change.
REQ-045 start pulsed during WRITE -> ignored; SEQ_PERF_CNT_EN defined with w_len=i_len=1 -> perf_cycles equals the observed busy-cycle count.
